// File: rtl/icache_pkg.sv
// Shared widths and the I/O region decode used by the instruction cache.
package icache_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam int          IO_MSB    = 17;
    localparam int          IO_LSB    = 16;
    localparam logic [1:0]  IO_REGION = 2'b11;

    // I/O space is uncacheable: such addresses always miss and never fill.
    function automatic logic is_io(input logic [IO_MSB-IO_LSB:0] region);
        return region == IO_REGION;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    // Request/response: in_fetch_ena stays high until the one-cycle out_fetch_ok pulse;
    // out_mem_ena stays high until the one-cycle in_mem_ok pulse. ena=0 stalls everything.
    logic                  ena;
    logic                  in_rollback;
    logic                  in_fetch_ena;
    logic [ADDR_WIDTH-1:0] in_fetch_addr;
    logic                  out_fetch_ok;
    logic [DATA_WIDTH-1:0] out_fetch_inst;
    logic                  out_mem_ena;
    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic                  in_mem_ok;
    logic [DATA_WIDTH-1:0] in_mem_data;

    modport slave (
        input  ena, in_rollback, in_fetch_ena, in_fetch_addr, in_mem_ok, in_mem_data,
        output out_fetch_ok, out_fetch_inst, out_mem_ena, out_mem_addr
    );

    modport master (
        output ena, in_rollback, in_fetch_ena, in_fetch_addr, in_mem_ok, in_mem_data,
        input  out_fetch_ok, out_fetch_inst, out_mem_ena, out_mem_addr
    );

endinterface

// File: rtl/icache_store.sv
// Direct-mapped line storage: valid bits, tags and data words, one read and one write port.
module icache_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags  [LINES];
    logic [DATA_WIDTH-1:0] words [LINES];

    // Only the valid bits need clearing; stale tags/data are masked by them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = words[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with IDLE/LOOKUP/REFILL control and rollback flush.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic       clk,
    input  logic       rst,
    icache_if.slave    bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, REFILL = 2'd2} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ok_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic                  mem_ena_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [INDEX_BITS-1:0] line_idx;
    logic [TAG_BITS-1:0]   line_tag;
    logic                  io;
    logic                  hit;
    logic                  mem_done;
    logic                  resp_now;
    logic                  fill_we;

    assign line_idx = addr[INDEX_BITS+1:2];
    assign line_tag = addr[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign io       = is_io(addr[IO_MSB:IO_LSB]);
    assign hit      = rd_valid && (rd_tag == line_tag) && !io;

    // A refill answer fills the line even under rollback; only the response is dropped.
    assign mem_done = rst && bus.ena && (state == REFILL) && bus.in_mem_ok;
    assign fill_we  = mem_done && !io;
    assign resp_now = mem_done && !bus.in_rollback;

    icache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (line_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill_we),
        .wr_idx   (line_idx),
        .wr_tag   (line_tag),
        .wr_data  (bus.in_mem_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            addr       <= '0;
            ok_q       <= 1'b0;
            inst_q     <= '0;
            mem_ena_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (bus.ena) begin
            ok_q <= 1'b0;
            case (state)
                IDLE: begin
                    // While a hit response is on the bus, in_fetch_ena still belongs to it.
                    if (bus.in_fetch_ena && !bus.in_rollback && !ok_q) begin
                        addr  <= bus.in_fetch_addr;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (bus.in_rollback) begin
                        state <= IDLE;
                    end else if (hit) begin
                        ok_q   <= 1'b1;
                        inst_q <= rd_data;
                        state  <= IDLE;
                    end else begin
                        mem_ena_q  <= 1'b1;
                        mem_addr_q <= addr;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.in_rollback) begin
                        mem_ena_q <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.in_mem_ok) begin
                        inst_q    <= bus.in_mem_data;
                        mem_ena_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_fetch_ok   = (ok_q && !bus.in_rollback) || resp_now;
    assign bus.out_fetch_inst = resp_now ? bus.in_mem_data : inst_q;
    assign bus.out_mem_ena    = mem_ena_q;
    assign bus.out_mem_addr   = mem_addr_q;
    assign dbg_state          = state;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: scripted fetcher/memory driver, cycle-level expectations and response queue.
module tb_icache;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  icache_if bus();

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        exp_ok = 1'b0;
  logic        exp_mem_ena = 1'b0;
  logic [31:0] exp_mem_addr = 32'h0;
  logic        mon_on = 1'b0;
  logic        prev_ok = 1'b0;
  logic        prev_mem_ena = 1'b0;
  int          cyc = 0;
  int          req_cyc = 0;
  int          ok_cyc = 0;
  int          refills = 0;
  logic [31:0] last_inst = 32'h0;
  logic [31:0] line_addr [int];

  always @(posedge clk) cyc = cyc + 1;

  // Backing memory contents: a fixed scramble of the address, 0x0 holds 0x00000013.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h01000193) ^ 32'h00000013;
  endfunction

  function automatic bit is_io_addr(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[8:2]);
    if (is_io_addr(a)) return 1'b0;
    if (!line_addr.exists(idx)) return 1'b0;
    return line_addr[idx] == a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("fetch_ok", 32'(bus.out_fetch_ok), 32'(exp_ok));
      check("mem_ena", 32'(bus.out_mem_ena), 32'(exp_mem_ena));
      if (exp_mem_ena) check("mem_addr", bus.out_mem_addr, exp_mem_addr);
      if (bus.out_fetch_ok) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_inst actual=%h required=<no response pending> (cycle %0d)",
                   bus.out_fetch_inst, cyc);
        end else begin
          check("fetch_inst", bus.out_fetch_inst, exp_q.pop_front());
        end
        last_inst = bus.out_fetch_inst;
        ok_cyc = cyc;
      end
      check("ok_single_cycle", 32'(bus.out_fetch_ok && prev_ok), 32'h0);
      check("ok_under_rollback", 32'(bus.out_fetch_ok && bus.in_rollback), 32'h0);
      if (bus.out_mem_ena && !prev_mem_ena) refills++;
      prev_ok = bus.out_fetch_ok;
      prev_mem_ena = bus.out_mem_ena;
    end
  end

  // rb_mode: 0 none, 1 rollback in LOOKUP, 2 rollback on the in_mem_ok cycle,
  // 3 rollback mid-refill followed by a stray in_mem_ok.
  task automatic do_fetch(input logic [31:0] a, input int rb_mode, input bit stall, input int delay);
    bit hit;
    bit io;
    int idx;
    io  = is_io_addr(a);
    idx = int'(a[8:2]);
    hit = model_hit(a);
    step();
    bus.in_fetch_ena = 1'b1;
    bus.in_fetch_addr = a;
    exp_ok = 1'b0;
    exp_mem_ena = 1'b0;
    req_cyc = cyc;
    step();
    if (rb_mode == 1) begin
      bus.in_rollback = 1'b1;
      bus.in_fetch_ena = 1'b0;
      step();
      bus.in_rollback = 1'b0;
      return;
    end
    step();
    if (hit) begin
      exp_ok = 1'b1;
      exp_q.push_back(mem_word(a));
      step();
      bus.in_fetch_ena = 1'b0;
      exp_ok = 1'b0;
      return;
    end
    exp_mem_ena = 1'b1;
    exp_mem_addr = a;
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        step();
        bus.ena = 1'b0;
        bus.in_mem_ok = (i == 2);
        bus.in_mem_data = $urandom;
      end
      step();
      bus.ena = 1'b1;
      bus.in_mem_ok = 1'b0;
    end
    repeat (delay) step();
    if (rb_mode == 3) begin
      step();
      bus.in_rollback = 1'b1;
      bus.in_fetch_ena = 1'b0;
      step();
      bus.in_rollback = 1'b0;
      bus.in_mem_ok = 1'b1;
      bus.in_mem_data = $urandom;
      exp_mem_ena = 1'b0;
      step();
      bus.in_mem_ok = 1'b0;
      return;
    end
    step();
    bus.in_mem_ok = 1'b1;
    bus.in_mem_data = mem_word(a);
    if (rb_mode == 2) begin
      bus.in_rollback = 1'b1;
    end else begin
      exp_ok = 1'b1;
      exp_q.push_back(mem_word(a));
    end
    if (!io) line_addr[idx] = a;
    step();
    bus.in_mem_ok = 1'b0;
    bus.in_rollback = 1'b0;
    bus.in_fetch_ena = 1'b0;
    exp_ok = 1'b0;
    exp_mem_ena = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    line_addr.delete();
  endtask

  initial begin
    int r0;
    logic [31:0] a;
    rst = 1'b0;
    bus.ena = 1'b1;
    bus.in_rollback = 1'b0;
    bus.in_fetch_ena = 1'b0;
    bus.in_fetch_addr = 32'h0;
    bus.in_mem_ok = 1'b0;
    bus.in_mem_data = 32'h0;
    step();
    step();
    check("rst_fetch_ok", 32'(bus.out_fetch_ok), 32'h0);
    check("rst_mem_ena", 32'(bus.out_mem_ena), 32'h0);
    check("rst_mem_addr", bus.out_mem_addr, 32'h0);
    check("rst_fetch_inst", bus.out_fetch_inst, 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    mon_on = 1'b1;
    rst = 1'b1;

    // Cold fetch then refetch of 0x0000.
    do_fetch(32'h0, 0, 1'b0, 1);
    check("cold_refills", 32'(refills), 32'd1);
    check("cold_inst", last_inst, 32'h00000013);
    do_fetch(32'h0, 0, 1'b0, 0);
    check("hit_latency", 32'(ok_cyc - req_cyc), 32'd2);
    check("hit_no_refill", 32'(refills), 32'd1);
    check("hit_inst", last_inst, 32'h00000013);

    // Conflict on index 0 from a cold cache.
    do_reset();
    r0 = refills;
    do_fetch(32'h0, 0, 1'b0, 0);
    do_fetch(32'h200, 0, 1'b0, 2);
    do_fetch(32'h0, 0, 1'b0, 1);
    check("conflict_refills", 32'(refills - r0), 32'd3);
    check("conflict_inst", last_inst, 32'h00000013);

    // Rollback coinciding with in_mem_ok still fills the line.
    r0 = refills;
    do_fetch(32'h40, 2, 1'b0, 1);
    do_fetch(32'h40, 0, 1'b0, 0);
    check("rb_fill_refills", 32'(refills - r0), 32'd1);
    check("rb_fill_latency", 32'(ok_cyc - req_cyc), 32'd2);

    // ena low mid-refill with a stray in_mem_ok pulse.
    r0 = refills;
    do_fetch(32'h80, 0, 1'b1, 1);
    check("stall_refills", 32'(refills - r0), 32'd1);
    check("stall_inst", last_inst, mem_word(32'h80));

    // I/O space never fills.
    r0 = refills;
    do_fetch(32'h30000, 0, 1'b0, 0);
    do_fetch(32'h30000, 0, 1'b0, 1);
    check("io_refills", 32'(refills - r0), 32'd2);

    // Rollback in LOOKUP and mid-refill drop the request.
    do_fetch(32'h0C0, 1, 1'b0, 0);
    do_fetch(32'h0C0, 3, 1'b0, 1);
    r0 = refills;
    do_fetch(32'h0C0, 0, 1'b0, 0);
    check("rb_drop_refills", 32'(refills - r0), 32'd1);

    // Reset mid-refill, coinciding with in_mem_ok, abandons the fill and clears the cache.
    step();
    bus.in_fetch_ena = 1'b1;
    bus.in_fetch_addr = 32'h100;
    step();
    step();
    exp_mem_ena = 1'b1;
    exp_mem_addr = 32'h100;
    step();
    rst = 1'b0;
    bus.in_mem_ok = 1'b1;
    bus.in_mem_data = mem_word(32'h100);
    step();
    rst = 1'b1;
    bus.in_mem_ok = 1'b0;
    bus.in_fetch_ena = 1'b0;
    exp_mem_ena = 1'b0;
    line_addr.delete();
    check("midrst_mem_addr", bus.out_mem_addr, 32'h0);
    check("midrst_state", 32'(dbg_state), 32'h0);
    r0 = refills;
    do_fetch(32'h100, 0, 1'b0, 0);
    do_fetch(32'h0, 0, 1'b0, 0);
    check("midrst_refills", 32'(refills - r0), 32'd2);

    // Randomized traffic over a small address pool to mix hits, misses and conflicts.
    for (int n = 0; n < 300; n++) begin
      int rsel;
      int mode;
      if ($urandom_range(0, 9) == 0)
        a = 32'h30000 | (32'($urandom_range(0, 3)) << 2);
      else
        a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 2);
      rsel = $urandom_range(0, 9);
      mode = (rsel <= 6) ? 0 : rsel - 6;
      do_fetch(a, mode, ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    check("pending_at_end", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 7, sets the number of lines to 2^INDEX_BITS (one 32-bit word per line, direct-mapped).
REQ-002 Parameter TAG_BITS, default 16-INDEX_BITS, holds address bits [17:INDEX_BITS+2].
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 ena  in  1  ready; when low, all state and outputs hold.
REQ-006 in_rollback  in  1  misprediction flush from the pc stage.
REQ-007 in_fetch_ena  in  1  fetcher request, held high until out_fetch_ok.
REQ-008 in_fetch_addr  in  32  instruction address, word-aligned.
REQ-009 out_fetch_ok  out  1  one-cycle pulse: out_fetch_inst is valid.
REQ-010 out_fetch_inst  out  32  returned instruction.
REQ-011 out_mem_ena  out  1  refill request to the memory unit, held until in_mem_ok.
REQ-012 out_mem_addr  out  32  refill address, equal to the missed in_fetch_addr.
REQ-013 in_mem_ok  in  1  one-cycle pulse: in_mem_data is valid.
REQ-014 in_mem_data  in  32  refilled word.

Function
REQ-015 FSM states: IDLE, LOOKUP, REFILL.
REQ-016 IDLE with in_fetch_ena=1 and no rollback: latch the address, go to LOOKUP.
REQ-017 LOOKUP on hit (valid[idx] and tag match): assert out_fetch_ok with the stored word, return to IDLE. Hit latency is 2 cycles from request to ok.
REQ-018 LOOKUP on miss: assert out_mem_ena and out_mem_addr the next cycle, go to REFILL.
REQ-019 REFILL on in_mem_ok: write data and tag, set valid[idx], pulse out_fetch_ok with in_mem_data in the same cycle, deassert out_mem_ena, go to IDLE.
REQ-020 Addresses with bits [17:16]=2'b11 (I/O space) always miss and are never filled.
REQ-021 out_fetch_ok is never high for two consecutive cycles.
REQ-022 out_fetch_ok is low in any cycle where in_rollback=1.
REQ-023 in_rollback in LOOKUP or REFILL: go to IDLE next cycle, deassert out_mem_ena, and drop the pending response.
REQ-024 If in_mem_ok and in_rollback coincide, the line is still filled (the data is correct for its address) but out_fetch_ok stays low.
REQ-025 in_mem_ok outside REFILL is ignored.
REQ-026 ena=0 freezes FSM, arrays and outputs, including mid-refill; in_mem_ok is not sampled while ena=0.
REQ-027 Cache contents survive rollback; only reset clears valid bits.

Reset
REQ-028 rst=0 at a clock edge: FSM to IDLE, all valid bits to 0, out_fetch_ok=0, out_mem_ena=0, out_mem_addr=0, out_fetch_inst=0.
REQ-029 Reset takes priority over ena, rollback and in_mem_ok.
REQ-030 Reset asserted mid-refill abandons the refill with no fill.

Structure
REQ-031 DATA_WIDTH, ADDR_WIDTH and the I/O region decode belong in the shared definitions include; the FSM state encodings are local to icache.
REQ-032 One sub-module, icache_store, holds the valid, tag and data arrays with a single read port and a single write port.

Verification
REQ-033 Cold fetch of 0x0000: out_mem_ena=1 with out_mem_addr=0x0; memory returns 0x00000013 -> out_fetch_ok on that cycle with 0x00000013.
REQ-034 Refetch of 0x0000 -> out_fetch_ok 2 cycles after the request with 0x00000013 and no out_mem_ena.
REQ-035 Conflict case with INDEX_BITS=7: fetch 0x0000, then 0x0200 (same index), then 0x0000 -> three refills, and each return carries the correct word.
REQ-036 Rollback during REFILL for 0x0040 with in_mem_ok on the same cycle -> out_fetch_ok stays 0; a later fetch of 0x0040 hits.
REQ-037 ena held low for 5 cycles mid-refill while in_mem_ok pulses -> no state change and the pulse is ignored; after ena returns, the request completes once memory answers.
REQ-038 Fetch of 0x30000 twice -> two refills and no fill.
